fill_arb: RTL
=============

# fill_arb

Round-robin arbiter and flow controller in front of the DRAM-cache fill FIFO. It shares the single FIFO push port (576-bit entry: 64-bit address over 512-bit line) among NUM_REQ line producers, such as memory-read fills and victim writebacks. It throttles on the FIFO almost-full flag and on a cap of outstanding AXI write responses. It also sequences a drain/quiesce handshake that cache flush and reset sequencing use.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MAX_OUTST, 16, maximum writes pushed but not yet acknowledged on B channel (1..255)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester line valid
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_addr_i  in  NUM_REQ*64  per-requester line address, requester i at [64*i+63:64*i]
- req_data_i  in  NUM_REQ*512  per-requester line data, requester i at [512*i+511:512*i]
- fifo_afull_i  in  1  fill FIFO almost full
- fifo_wren_o  out  1  fill FIFO push strobe
- fifo_data_o  out  576  push entry: [575:512]=address, [511:0]=data
- bvalid_i  in  1  AXI write response valid
- bid_i  in  16  AXI write response ID (unused, only for debug visibility)
- bready_o  out  1  AXI write response ready
- drain_i  in  1  request quiesce (level)
- drained_o  out  1  quiesced: no acceptance and zero outstanding
- outst_o  out  8  current outstanding count
- err_o  out  1  sticky: B response received with zero outstanding

## Operation
- State machine with states RUN, DRAIN and DONE. It resets to RUN.
  - RUN -> DRAIN when drain_i=1.
  - DRAIN -> DONE when outst==0 and fifo_wren_o==0.
  - DONE -> RUN when drain_i=0.
  - DRAIN -> RUN when drain_i drops before DONE.
- Acceptance is enabled only in RUN, with fifo_afull_i=0 and (outst + fifo_wren_o) < MAX_OUTST.
- Arbitration is round-robin with priority pointer ptr (reset 0).
  - The winner is the first i, scanning from ptr upward modulo NUM_REQ, with req_valid_i[i]=1.
  - req_ready_o[winner]=1 combinationally when enabled.
  - On accept of winner w, ptr <= (w+1) mod NUM_REQ. Otherwise ptr holds.
  - Non-winning valid requesters see ready=0 and must hold their valid, address and data stable.
- The accepted address and data are registered into fifo_data_o. fifo_wren_o pulses for exactly one cycle per accept.
- Outstanding counter outst:
  - +1 on each fifo_wren_o.
  - −1 on each bvalid_i & bready_o.
  - A simultaneous increment and decrement leaves it unchanged.
  - It never exceeds MAX_OUTST.
- bready_o=1 whenever out of reset.
- If bvalid_i arrives with outst==0 (and no push that cycle), the counter stays 0 and err_o sets. err_o clears only on reset.
- drained_o=1 exactly in DONE.

## Timing
- Reset values:
  - req_ready_o=0, fifo_wren_o=0, fifo_data_o=0, bready_o=0, outst_o=0, drained_o=0, err_o=0
  - ptr=0, state=RUN
- Accept at edge N results in fifo_wren_o=1 with matching data during cycle N+1. Latency is 1 cycle.
- fifo_afull_i is sampled combinationally in the accept cycle. The FIFO guarantees at least 1 free slot while afull=1, for the in-flight push.
- outst_o updates at the edge after the push or response, i.e. it is registered.
- drain_i asserted in cycle N blocks acceptance in cycle N+1 onward. An accept in cycle N itself still completes.
- Reset asserted mid-operation immediately clears every output and discards the registered push. fifo_wren_o goes low asynchronously.
- Back-to-back accepts, one per cycle, are allowed. Sustained throughput is 1 line per cycle while enabled.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0, release, leave all inputs 0 for 5 cycles.
  - Required response: all outputs at their reset values; after release bready_o=1, drained_o=0, fifo_wren_o never pulses.
- Round-robin:
  - Stimulus: NUM_REQ=2, both valid continuously, addresses 0x1000/0x2000, 6 accepts.
  - Required response: pushes alternate 0x1000, 0x2000, 0x1000, …; fifo_data_o[575:512] matches each push; one fifo_wren_o per accept.
- Almost-full:
  - Stimulus: req0 valid, fifo_afull_i=1 for 4 cycles, then 0.
  - Required response: req_ready_o=0 for those 4 cycles; accept on the first afull=0 cycle; fifo_wren_o the next cycle.
- Outstanding cap:
  - Stimulus: MAX_OUTST=4, no B responses, req0 always valid.
  - Required response: exactly 4 pushes, then ready=0 with outst_o=4; one bvalid_i pulse frees exactly one more push.
  - Stimulus: simultaneous push and B response.
  - Required response: outst_o unchanged.
- Drain:
  - Stimulus: outst_o=3, assert drain_i, then return 3 B responses.
  - Required response: no accepts after drain; drained_o=1 on the cycle after outst_o reaches 0; drain_i=0 returns to RUN and accepts resume.
- Error/underflow and mid-reset:
  - Stimulus: bvalid_i with outst_o=0.
  - Required response: err_o=1 sticky, outst_o stays 0.
  - Stimulus: reset pulse during a push.
  - Required response: fifo_wren_o=0, outst_o=0, err_o=0.

Source files
------------

// File: rtl/fill_arb.sv
// rtl/fill_arb.sv - round-robin arbiter and flow control for the DRAM-cache fill FIFO push port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid_i/ready_o per-requester handshake, at most one ready bit high per cycle
//   req_addr_i/data_i   per-requester line address (64b) and data (512b), flattened
//   fifo_afull_i        fill FIFO almost full, blocks acceptance in the same cycle
//   fifo_wren_o/data_o  registered push strobe and {address, data} entry
//   bvalid_i/bid_i      AXI write response (bid_i is debug-only)
//   bready_o            always ready while out of reset
//   drain_i/drained_o   quiesce request (level) and quiesced status
//   outst_o             writes pushed but not yet acknowledged
//   err_o               sticky: write response received with nothing outstanding
module fill_arb #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_OUTST = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*64-1:0]  req_addr_i,
    input  logic [NUM_REQ*512-1:0] req_data_i,
    input  logic                   fifo_afull_i,
    output logic                   fifo_wren_o,
    output logic [575:0]           fifo_data_o,
    input  logic                   bvalid_i,
    input  logic [15:0]            bid_i,
    output logic                   bready_o,
    input  logic                   drain_i,
    output logic                   drained_o,
    output logic [7:0]             outst_o,
    output logic                   err_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [7:0]     outst_q, outst_d;
    logic           err_q, err_d;
    logic           wren_q;
    logic [575:0]   data_q, data_d;

    logic [PW-1:0]  win_idx;
    logic           win_found;
    logic [PW:0]    scan_sum;
    logic [PW-1:0]  scan_idx;
    logic           accept_en;
    logic           accept;
    logic           inc, dec;
    logic           unused_bid;

    assign unused_bid = ^bid_i;

    // Response channel is never back-pressured; gating with rst_n keeps it low in reset.
    assign bready_o = rst_n;

    // Round-robin scan starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // The push already in flight (wren_q) counts against the cap, since outst_q
    // only sees it one edge later.
    always_comb begin
        accept_en = rst_n && (state_q == S_RUN) && !fifo_afull_i &&
                    (({1'b0, outst_q} + {8'b0, wren_q}) < 9'(MAX_OUTST));
        accept      = accept_en && win_found;
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        if (accept) begin
            ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_idx == PW'(i)) begin
                    data_d = {req_addr_i[64*i +: 64], req_data_i[512*i +: 512]};
                end
            end
        end
    end

    // Outstanding write counter; a response with nothing outstanding is an error
    // and leaves the counter at zero.
    always_comb begin
        inc     = wren_q;
        dec     = bvalid_i && bready_o;
        outst_d = outst_q;
        err_d   = err_q;
        if (inc && !dec) begin
            outst_d = outst_q + 8'd1;
        end else if (dec && !inc) begin
            if (outst_q == 8'd0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (drain_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!drain_i) begin
                    state_d = S_RUN;
                end else if ((outst_q == 8'd0) && !wren_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!drain_i) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            wren_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            wren_q  <= accept;
            data_q  <= data_d;
        end
    end

    assign fifo_wren_o = wren_q;
    assign fifo_data_o = data_q;
    assign outst_o     = outst_q;
    assign drained_o   = (state_q == S_DONE);
    assign err_o       = err_q;

endmodule
